// File: rtl/nios0_ip_onchip_mem_arbiter.sv
// Purpose: two-port Avalon-MM arbiter in front of one single-port on-chip RAM (round-robin on conflict).
// Latency: grant is combinational in the request cycle; read data returns exactly one cycle after the grant.
// Backpressure: the losing or idle port sees waitrequest=1; out-of-range accesses are accepted but never reach the RAM.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   p0_*/p1_*                  Avalon-MM agent ports (address, byteenable, read, write, writedata,
//                              waitrequest, readdata, readdatavalid)
//   mem_*                      single-port RAM side (registered address, 1-cycle read latency)
//   oor_err, oor_port          sticky out-of-range flag and the port that first raised it
//   grant_cnt0, grant_cnt1     wrapping accepted-transaction counters per port
module nios0_ip_onchip_mem_arbiter #(
    parameter int DEPTH = 25600,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          reset,

    input  logic [AW-1:0] p0_address,
    input  logic [3:0]    p0_byteenable,
    input  logic          p0_read,
    input  logic          p0_write,
    input  logic [31:0]   p0_writedata,
    output logic          p0_waitrequest,
    output logic [31:0]   p0_readdata,
    output logic          p0_readdatavalid,

    input  logic [AW-1:0] p1_address,
    input  logic [3:0]    p1_byteenable,
    input  logic          p1_read,
    input  logic          p1_write,
    input  logic [31:0]   p1_writedata,
    output logic          p1_waitrequest,
    output logic [31:0]   p1_readdata,
    output logic          p1_readdatavalid,

    output logic [AW-1:0] mem_address,
    output logic [3:0]    mem_byteenable,
    output logic          mem_chipselect,
    output logic          mem_write,
    output logic [31:0]   mem_writedata,
    output logic          mem_clken,
    input  logic [31:0]   mem_readdata,

    output logic          oor_err,
    output logic          oor_port,
    output logic [15:0]   grant_cnt0,
    output logic [15:0]   grant_cnt1
);

    // last_grant: 0 = port 0 won most recently, 1 = port 1 won most recently
    logic          last_grant;
    logic          req0, req1;
    logic          gnt0, gnt1, any_gnt;
    logic          win_write;
    logic [AW-1:0] win_addr;
    logic          in_range;

    // Read-return pipeline: one slot, since at most one read is granted per cycle
    logic          rd_vld_q;
    logic          rd_port_q;
    logic          rd_oor_q;
    logic          rd_live;

    logic          oor_err_q;
    logic          oor_port_q;
    logic [15:0]   cnt0_q, cnt1_q;

    always_comb begin
        req0 = p0_read | p0_write;
        req1 = p1_read | p1_write;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        // Nothing is granted while reset is held, so waitrequest stays high
        if (!reset) begin
            if (req0 && req1) begin
                gnt0 = last_grant;
                gnt1 = ~last_grant;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
        any_gnt = gnt0 | gnt1;

        // A simultaneous read+write is a write; the read strobe is ignored
        win_write = gnt1 ? p1_write : p0_write;
        win_addr  = gnt1 ? p1_address : p0_address;
        in_range  = (32'(win_addr) < 32'(DEPTH));

        p0_waitrequest = ~gnt0;
        p1_waitrequest = ~gnt1;

        mem_address    = win_addr;
        mem_byteenable = gnt1 ? p1_byteenable : p0_byteenable;
        mem_writedata  = gnt1 ? p1_writedata : p0_writedata;
        mem_chipselect = any_gnt & in_range;
        mem_write      = any_gnt & in_range & win_write;
        mem_clken      = ~reset;
    end

    // A read pending into a reset cycle is dropped, even before the register clears
    always_comb begin
        rd_live          = rd_vld_q & ~reset;
        p0_readdatavalid = rd_live & ~rd_port_q;
        p1_readdatavalid = rd_live & rd_port_q;
        p0_readdata      = (p0_readdatavalid && !rd_oor_q) ? mem_readdata : 32'h0;
        p1_readdata      = (p1_readdatavalid && !rd_oor_q) ? mem_readdata : 32'h0;

        // Status reads as reset values for the whole reset window, including its first cycle
        oor_err    = oor_err_q & ~reset;
        oor_port   = oor_port_q & ~reset;
        grant_cnt0 = reset ? 16'h0 : cnt0_q;
        grant_cnt1 = reset ? 16'h0 : cnt1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            rd_vld_q   <= 1'b0;
            rd_port_q  <= 1'b0;
            rd_oor_q   <= 1'b0;
            oor_err_q  <= 1'b0;
            oor_port_q <= 1'b0;
            cnt0_q     <= 16'h0;
            cnt1_q     <= 16'h0;
        end else begin
            rd_vld_q  <= any_gnt & ~win_write;
            rd_port_q <= gnt1;
            rd_oor_q  <= ~in_range;
            if (any_gnt) begin
                last_grant <= gnt1;
            end
            if (gnt0) begin
                cnt0_q <= cnt0_q + 16'd1;
            end
            if (gnt1) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
            // Only the first out-of-range access records its port
            if (any_gnt && !in_range && !oor_err_q) begin
                oor_err_q  <= 1'b1;
                oor_port_q <= gnt1;
            end
        end
    end

endmodule

// File: tb/tb_nios0_ip_onchip_mem_arbiter.sv
// Purpose: self-checking bench for nios0_ip_onchip_mem_arbiter with a behavioural RAM.
// Latency: expected read responses are queued at grant time and popped by a monitor one cycle later.
// Backpressure: waitrequest and memory-side strobes are checked directly in each stimulus cycle.
module tb_nios0_ip_onchip_mem_arbiter;

    localparam int AW    = 15;
    localparam int DEPTH = 25600;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] p0_address, p1_address;
    logic [3:0]    p0_byteenable, p1_byteenable;
    logic          p0_read, p0_write, p1_read, p1_write;
    logic [31:0]   p0_writedata, p1_writedata;
    logic          p0_waitrequest, p1_waitrequest;
    logic [31:0]   p0_readdata, p1_readdata;
    logic          p0_readdatavalid, p1_readdatavalid;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [31:0]   mem_writedata;
    logic [31:0]   mem_readdata;
    logic          oor_err, oor_port;
    logic [15:0]   grant_cnt0, grant_cnt1;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    logic [31:0] ram [0:(1<<AW)-1];

    nios0_ip_onchip_mem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .p0_address       (p0_address),
        .p0_byteenable    (p0_byteenable),
        .p0_read          (p0_read),
        .p0_write         (p0_write),
        .p0_writedata     (p0_writedata),
        .p0_waitrequest   (p0_waitrequest),
        .p0_readdata      (p0_readdata),
        .p0_readdatavalid (p0_readdatavalid),
        .p1_address       (p1_address),
        .p1_byteenable    (p1_byteenable),
        .p1_read          (p1_read),
        .p1_write         (p1_write),
        .p1_writedata     (p1_writedata),
        .p1_waitrequest   (p1_waitrequest),
        .p1_readdata      (p1_readdata),
        .p1_readdatavalid (p1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .oor_err          (oor_err),
        .oor_port         (oor_port),
        .grant_cnt0       (grant_cnt0),
        .grant_cnt1       (grant_cnt1)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: registered address, read-before-write, 1-cycle latency
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            mem_readdata <= ram[mem_address];
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) begin
                        ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h, required %08h", name, act, req);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        p0_read = 1'b0; p0_write = 1'b0; p1_read = 1'b0; p1_write = 1'b0;
    endtask

    task automatic push(input logic port, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
    endtask

    // Monitor: sampled after the stimulus process has queued this cycle's expectations
    always begin
        @(negedge clk);
        #2;
        check("rdv_exclusive", {31'b0, p0_readdatavalid & p1_readdatavalid}, 32'h0);
        if (!p0_readdatavalid) check("p0_rdata_idle", p0_readdata, 32'h0);
        if (!p1_readdatavalid) check("p1_rdata_idle", p1_readdata, 32'h0);
        if (p0_readdatavalid || p1_readdatavalid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rdv: got p0=%0b p1=%0b data=%08h, required none",
                         p0_readdatavalid, p1_readdatavalid,
                         p0_readdatavalid ? p0_readdata : p1_readdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rd_port", {31'b0, p1_readdatavalid}, {31'b0, e.port});
                check("rd_data", p1_readdatavalid ? p1_readdata : p0_readdata, e.data);
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
        ram[5] = 32'hCAFE0005;
        mem_readdata = 32'h0;
        reset = 1'b1;
        idle();
        p0_address = '0; p1_address = '0;
        p0_byteenable = 4'hF; p1_byteenable = 4'hF;
        p0_writedata = 32'h0; p1_writedata = 32'h0;

        // Reset state while port 0 is already requesting
        p0_read = 1'b1; p0_address = 15'd5;
        @(negedge clk);
        check("rst_p0_wait", {31'b0, p0_waitrequest}, 32'h1);
        check("rst_p1_wait", {31'b0, p1_waitrequest}, 32'h1);
        check("rst_clken", {31'b0, mem_clken}, 32'h0);
        check("rst_cs", {31'b0, mem_chipselect}, 32'h0);
        check("rst_oor", {31'b0, oor_err}, 32'h0);
        check("rst_cnt0", {16'b0, grant_cnt0}, 32'h0);
        step();
        step();
        reset = 1'b0;

        // First cycle out of reset: port 0 read of word 5
        @(negedge clk);
        check("r5_p0_wait", {31'b0, p0_waitrequest}, 32'h0);
        check("r5_p1_wait", {31'b0, p1_waitrequest}, 32'h1);
        check("r5_cs", {31'b0, mem_chipselect}, 32'h1);
        check("r5_we", {31'b0, mem_write}, 32'h0);
        check("r5_addr", {17'b0, mem_address}, 32'd5);
        check("r5_clken", {31'b0, mem_clken}, 32'h1);
        push(1'b0, 32'hCAFE0005);
        step();
        idle();
        @(negedge clk);
        check("idle_p0_wait", {31'b0, p0_waitrequest}, 32'h1);
        step();

        // Both ports writing continuously: p0,p1,p0,p1
        do_reset();
        p0_write = 1'b1; p0_address = 15'd10; p0_writedata = 32'hA0A0A0A0; p0_byteenable = 4'hF;
        p1_write = 1'b1; p1_address = 15'd11; p1_writedata = 32'hB1B1B1B1; p1_byteenable = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_p0_wait", {31'b0, p0_waitrequest}, (i % 2 == 1) ? 32'h1 : 32'h0);
            check("rr_p1_wait", {31'b0, p1_waitrequest}, (i % 2 == 1) ? 32'h0 : 32'h1);
            check("rr_we", {31'b0, mem_write}, 32'h1);
            step();
        end
        idle();
        @(negedge clk);
        check("rr_cnt0", {16'b0, grant_cnt0}, 32'd2);
        check("rr_cnt1", {16'b0, grant_cnt1}, 32'd2);
        step();

        // Port 1 partial write then read-back of word 7
        p1_write = 1'b1; p1_address = 15'd7; p1_writedata = 32'h11223344; p1_byteenable = 4'b0011;
        @(negedge clk);
        check("bw_p1_wait", {31'b0, p1_waitrequest}, 32'h0);
        check("bw_we", {31'b0, mem_write}, 32'h1);
        check("bw_be", {28'b0, mem_byteenable}, 32'h3);
        step();
        p1_write = 1'b0; p1_read = 1'b1; p1_byteenable = 4'hF;
        @(negedge clk);
        check("br_p1_wait", {31'b0, p1_waitrequest}, 32'h0);
        push(1'b1, 32'h00003344);
        step();
        idle();

        // Out-of-range read on port 1, then out-of-range write on port 0
        p1_read = 1'b1; p1_address = 15'd25600;
        @(negedge clk);
        check("oor_rd_wait", {31'b0, p1_waitrequest}, 32'h0);
        check("oor_rd_cs", {31'b0, mem_chipselect}, 32'h0);
        push(1'b1, 32'h0);
        step();
        idle();
        @(negedge clk);
        check("oor_err1", {31'b0, oor_err}, 32'h1);
        check("oor_port1", {31'b0, oor_port}, 32'h1);
        step();
        p0_write = 1'b1; p0_address = 15'd30000; p0_writedata = 32'hDEADBEEF;
        @(negedge clk);
        check("oor_wr_wait", {31'b0, p0_waitrequest}, 32'h0);
        check("oor_wr_cs", {31'b0, mem_chipselect}, 32'h0);
        check("oor_wr_we", {31'b0, mem_write}, 32'h0);
        step();
        idle();
        @(negedge clk);
        check("oor_err2", {31'b0, oor_err}, 32'h1);
        check("oor_port_kept", {31'b0, oor_port}, 32'h1);
        step();

        // Read+write together is a write with no read response; then read it back
        p0_read = 1'b1; p0_write = 1'b1; p0_address = 15'd3; p0_writedata = 32'h55AA55AA; p0_byteenable = 4'hF;
        @(negedge clk);
        check("rw_p0_wait", {31'b0, p0_waitrequest}, 32'h0);
        check("rw_we", {31'b0, mem_write}, 32'h1);
        check("rw_cs", {31'b0, mem_chipselect}, 32'h1);
        step();
        p0_write = 1'b0;
        @(negedge clk);
        push(1'b0, 32'h55AA55AA);
        step();

        // Alternating back-to-back reads; port 0 won last, so port 1 goes first
        p0_address = 15'd5; p0_read = 1'b1;
        p1_address = 15'd7; p1_read = 1'b1;
        @(negedge clk);
        check("alt1_p1_wait", {31'b0, p1_waitrequest}, 32'h0);
        check("alt1_p0_wait", {31'b0, p0_waitrequest}, 32'h1);
        push(1'b1, 32'h00003344);
        step();
        @(negedge clk);
        check("alt2_p0_wait", {31'b0, p0_waitrequest}, 32'h0);
        check("alt2_p1_wait", {31'b0, p1_waitrequest}, 32'h1);
        push(1'b0, 32'hCAFE0005);
        step();
        idle();

        // Read granted, reset pulsed next cycle: the response is dropped
        p0_read = 1'b1; p0_address = 15'd5;
        @(negedge clk);
        check("rp_p0_wait", {31'b0, p0_waitrequest}, 32'h0);
        step();
        reset = 1'b1;
        idle();
        @(negedge clk);
        check("rp_rdv", {31'b0, p0_readdatavalid}, 32'h0);
        check("rp_clken", {31'b0, mem_clken}, 32'h0);
        check("rp_oor_err", {31'b0, oor_err}, 32'h0);
        check("rp_oor_port", {31'b0, oor_port}, 32'h0);
        check("rp_cnt0", {16'b0, grant_cnt0}, 32'h0);
        check("rp_p0_wait_rst", {31'b0, p0_waitrequest}, 32'h1);
        step();
        reset = 1'b0;
        p0_read = 1'b1; p0_address = 15'd5;
        p1_read = 1'b1; p1_address = 15'd7;
        @(negedge clk);
        check("post_rst_p0_wait", {31'b0, p0_waitrequest}, 32'h0);
        check("post_rst_p1_wait", {31'b0, p1_waitrequest}, 32'h1);
        push(1'b0, 32'hCAFE0005);
        step();
        idle();
        step();
        step();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nios0_ip_onchip_mem_arbiter.md
NIOS0_IP_ONCHIP_MEM_ARBITER -- requirements
Module: nios0_ip_onchip_mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 25600, the number of implemented 32-bit words.
REQ-002 SHALL have parameter AW, default 15, the word address width.
REQ-003 SHALL have one clock and synchronous active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high.
REQ-004 SHALL have requester ports p0_/p1_ (x = 0,1), Avalon-MM agent side:
- px_address  in  AW  word address
- px_byteenable  in  4  byte lanes
- px_read  in  1  read request
- px_write  in  1  write request
- px_writedata  in  32  write data
- px_waitrequest  out  1  request not accepted this cycle
- px_readdata  out  32  read data
- px_readdatavalid  out  1  read data qualifier
REQ-005 SHALL have memory side, single-port RAM with registered address and 1-cycle read latency:
- mem_address  out  AW
- mem_byteenable  out  4
- mem_chipselect  out  1
- mem_write  out  1
- mem_writedata  out  32
- mem_clken  out  1
- mem_readdata  in  32
REQ-006 SHALL have status outputs:
- oor_err  out  1  sticky out-of-range flag
- oor_port  out  1  port of first out-of-range access
- grant_cnt0  out  16  accepted-transaction counter, port 0
- grant_cnt1  out  16  accepted-transaction counter, port 1

Function
REQ-007 A port requests when px_read or px_write is high; when both are high, the request SHALL be treated as a write, with the read ignored.
REQ-008 Arbitration SHALL be combinational in the request cycle, granting at most one port per cycle.
REQ-009 With one requester, that port SHALL be granted.
REQ-010 With two requesters, the port not granted most recently SHALL win; the last_grant register SHALL update only on a grant.
REQ-011 The winner's px_waitrequest SHALL be 0 in the grant cycle; a requesting loser SHALL see 1; an idle port SHALL see 1.
REQ-012 In a grant cycle with address < DEPTH, mem_chipselect SHALL be 1 and mem_address/byteenable/writedata SHALL mirror the winner's inputs; mem_write SHALL be 1 for writes only.
REQ-013 With no grant, or an out-of-range grant, mem_chipselect and mem_write SHALL be 0.
REQ-014 mem_clken SHALL be 1 except during reset, when it is 0.
REQ-015 A granted in-range read in cycle N SHALL assert px_readdatavalid for exactly cycle N+1, with px_readdata = mem_readdata in that cycle.
REQ-016 A granted out-of-range read (address >= DEPTH) SHALL be accepted, return px_readdata = 32'h0 with px_readdatavalid in N+1, and set oor_err.
REQ-017 A granted out-of-range write SHALL be accepted, perform no memory access, and set oor_err.
REQ-018 oor_port SHALL capture the port only on the access that first sets oor_err; later errors SHALL not change it.
REQ-019 Back-to-back grants SHALL be sustained at one transaction per cycle with no bubble, including alternating ports.
REQ-020 px_readdatavalid SHALL never be high on both ports in the same cycle.
REQ-021 px_readdata SHALL be 32'h0 whenever px_readdatavalid is 0.
REQ-022 grant_cntx SHALL increment on every grant to port x and wrap from 16'hFFFF to 0.

Reset
REQ-023 While reset is high: px_waitrequest=1, px_readdatavalid=0, px_readdata=0, mem_chipselect=0, mem_write=0, mem_clken=0, oor_err=0, oor_port=0, grant_cnt0/1=0; last_grant SHALL be set to port 1 so port 0 wins the first conflict.
REQ-024 A read granted in cycle N with reset asserted in N+1 SHALL produce no readdatavalid; the pending read is discarded.
REQ-025 The first grant SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-026 Port 0 read at addr 5, RAM word 5 = 32'hCAFE0005 -> p0_waitrequest=0 in N, p0_readdatavalid=1 with 32'hCAFE0005 in N+1, p1 outputs quiet.
REQ-027 Both ports write continuously for 4 cycles after reset -> grants in order p0,p1,p0,p1; each loser sees waitrequest=1; grant_cnt0=grant_cnt1=2.
REQ-028 Port 1 writes 32'h11223344 to addr 7 with byteenable 4'b0011, then reads addr 7, prior value 0 -> readdata 32'h00003344 one cycle after the read grant.
REQ-029 Port 1 reads addr 25600 -> accepted, mem_chipselect=0, p1_readdata=0 with readdatavalid in N+1, oor_err=1, oor_port=1; a later p0 error leaves oor_port=1.
REQ-030 p0 read granted, reset pulsed the next cycle -> no readdatavalid, all outputs at reset values, and after reset p0 wins the first conflict.
REQ-031 Port 0 drives read and write together to addr 3 -> write performed, no readdatavalid.
